// File: rtl/mem_port_arbiter.sv
// Purpose: shares one memory port between instruction fetch (I) and load/store (D), alternating priority on conflict.
// Latency: req in cycle 0 -> m_req in cycle 1; m_ack in cycle k -> x_done in cycle k+1; at least 3 cycles per access.
// Backpressure: the granted request is held on m_* until m_ack; the losing requester waits with req held high.
module mem_port_arbiter #(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          i_req,
    input  logic [AW-1:0] i_addr,
    output logic [DW-1:0] i_rdata,
    output logic          i_done,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic [DW-1:0] d_rdata,
    output logic          d_done,
    output logic          m_req,
    output logic          m_we,
    output logic [AW-1:0] m_addr,
    output logic [DW-1:0] m_wdata,
    input  logic [DW-1:0] m_rdata,
    input  logic          m_ack
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2,
        RESP   = 2'd3
    } state_t;

    localparam logic OWNER_I = 1'b0;
    localparam logic OWNER_D = 1'b1;

    state_t state;
    state_t state_nxt;
    logic   last_owner;
    logic   grant_i;
    logic   grant_d;

    // Grant decision in IDLE: on conflict D wins only if I was served last.
    always_comb begin
        grant_d = 1'b0;
        grant_i = 1'b0;
        if (state == IDLE) begin
            grant_d = d_req && (!i_req || (last_owner == OWNER_I));
            grant_i = i_req && !grant_d;
        end
    end

    // Next-state logic; RESP always returns to IDLE without sampling requests.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (grant_d) begin
                    state_nxt = BUSY_D;
                end else if (grant_i) begin
                    state_nxt = BUSY_I;
                end
            end
            BUSY_I:  if (m_ack) state_nxt = RESP;
            BUSY_D:  if (m_ack) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Registered outputs: launch the memory request on grant, capture data and pulse done on ack.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            last_owner <= OWNER_I;
            m_req      <= 1'b0;
            m_we       <= 1'b0;
            m_addr     <= '0;
            m_wdata    <= '0;
            i_done     <= 1'b0;
            d_done     <= 1'b0;
            i_rdata    <= '0;
            d_rdata    <= '0;
        end else begin
            i_done <= 1'b0;
            d_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_d) begin
                        last_owner <= OWNER_D;
                        m_req      <= 1'b1;
                        m_we       <= d_we;
                        m_addr     <= d_addr;
                        m_wdata    <= d_wdata;
                    end else if (grant_i) begin
                        last_owner <= OWNER_I;
                        m_req      <= 1'b1;
                        m_we       <= 1'b0;
                        m_addr     <= i_addr;
                        m_wdata    <= '0;
                    end
                end
                BUSY_I: begin
                    if (m_ack) begin
                        i_rdata <= m_rdata;
                        m_req   <= 1'b0;
                        i_done  <= 1'b1;
                    end
                end
                BUSY_D: begin
                    // Read data is captured for stores too; the owner may ignore it.
                    if (m_ack) begin
                        d_rdata <= m_rdata;
                        m_req   <= 1'b0;
                        d_done  <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
